regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised two-read / one-write register file for the CPU datapath.
- Width and depth are generic. Address 0 reads the external DIN bus, as in the current datapath.
- Adds an explicit write enable, asynchronous clear, and optional write-through bypass.
- Adds a per-register pending scoreboard so the control unit can stall on operands whose write-back has not yet happened.

Parameters:
- WIDTH, 8, data width of DIN, RIN, A and B.
- NREG, 8, number of addresses including address 0 (DIN). Storage registers are 1..NREG-1. Legal range is 2..2**AW.
- AW, 3, select width. Must satisfy 2**AW >= NREG.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads show the stored value only.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RSTN  in  1  asynchronous active-low reset.
- WE  in  1  write enable.
- DSEL  in  AW  write address.
- RIN  in  WIDTH  write data.
- RSV  in  1  reserve request (marks a register pending).
- RSEL  in  AW  reserve address.
- ASEL  in  AW  read address, port A.
- BSEL  in  AW  read address, port B.
- DIN  in  WIDTH  external operand, returned for address 0.
- A  out  WIDTH  read data, port A.
- B  out  WIDTH  read data, port B.
- ABUSY  out  1  operand A is pending.
- BBUSY  out  1  operand B is pending.
- PEND  out  NREG  scoreboard bit vector (bit 0 is always 0).

Behaviour:
- Reset: asserting RSTN low immediately clears every storage register and every pending bit to 0, independent of CLK.
  - During reset, A and B still follow their combinational rules: address 0 gives DIN, any other address gives 0.
  - ABUSY, BBUSY and PEND are 0 during reset.
  - Deassertion is not synchronised inside this block; the top level supplies a synchronised RSTN.
- Write: on a rising CLK edge with WE=1 and 0 < DSEL < NREG, register[DSEL] <= RIN.
  - Writes with DSEL=0 or DSEL >= NREG are ignored with no side effects.
- Read (combinational, zero latency), same rules for port A (ASEL) and port B (BSEL):
  - Address 0 returns DIN.
  - 1..NREG-1 returns the stored register.
  - Any address >= NREG returns 0.
- Bypass (BYPASS=1 only): if WE=1, DSEL=ASEL and 0 < ASEL < NREG, then A=RIN in the same cycle. Port B works identically with BSEL.
  - With BYPASS=0, the new value appears on the cycle after the write edge.
- Scoreboard (pending[i], one bit per storage register):
  - Set: on a rising edge with RSV=1 and 0 < RSEL < NREG, pending[RSEL] <= 1.
  - Clear: on a rising edge with WE=1 and 0 < DSEL < NREG, pending[DSEL] <= 0.
  - Same index set and cleared on one edge: set wins. This models a new producer issuing while the old one retires.
  - Different indices set and cleared on one edge: both take effect.
  - Writing a register that is not pending is legal; its pending bit stays 0.
  - Reserving an already-pending register is legal; its pending bit stays 1.
- Busy outputs:
  - ABUSY = pending[ASEL], forced to 0 for ASEL=0, for ASEL >= NREG, and (when BYPASS=1) when the bypass condition on port A is active.
  - BBUSY follows the same rules with BSEL.
- PEND:
  - PEND[i] = pending[i] for i in 1..NREG-1.
  - PEND[0] = 0.
- Simultaneous read and write to the same address with BYPASS=0: the read shows the old value and the busy output reflects the pre-edge pending bit.

Test Plan:
- Reset sweep: write 8'hA5 to all of R1..R7, pulse RSTN low mid-cycle (no clock edge). Required: all reads return 0 immediately, PEND=0, and ASEL=0 with DIN=8'h3C gives A=8'h3C.
- Write/read and WE gating:
  - WE=1, DSEL=3, RIN=8'h5A, then ASEL=3, BSEL=3 -> A=B=8'h5A on the next cycle.
  - WE=0, DSEL=3, RIN=8'hFF -> A stays 8'h5A.
  - WE=1, DSEL=0, RIN=8'h77 -> no register changes.
- Bypass: BYPASS=1, WE=1, DSEL=ASEL=5, RIN=8'h11 -> A=8'h11 in the same cycle before the edge. With BYPASS=0, same stimulus -> A holds the old R5 value until after the edge.
- Scoreboard:
  - RSV=1, RSEL=4 for one edge, then ASEL=4 -> ABUSY=1, PEND=8'b0001_0000.
  - WE=1, DSEL=4 -> PEND=0 after the edge, and ABUSY=0 during the write cycle when BYPASS=1.
- Simultaneous events:
  - Pending[2]=1, then on one edge RSV=1, RSEL=2 and WE=1, DSEL=2 -> pending[2] stays 1 and R2 is updated.
  - Same edge with RSEL=6, DSEL=2 -> pending[6]=1 and pending[2]=0.
- Non-power-of-2 depth: NREG=6, AW=3.
  - ASEL=7 -> A=0 and ABUSY=0.
  - WE=1, DSEL=6 -> ignored.
  - RSV=1, RSEL=7 -> PEND unchanged.

Source files
------------

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - two-read/one-write register file with DIN at address 0, write bypass and pending scoreboard
module regfile_param #(
    parameter int WIDTH  = 8,
    parameter int NREG   = 8,
    parameter int AW     = 3,
    parameter int BYPASS = 1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             WE,
    input  logic [AW-1:0]    DSEL,
    input  logic [WIDTH-1:0] RIN,
    input  logic             RSV,
    input  logic [AW-1:0]    RSEL,
    input  logic [AW-1:0]    ASEL,
    input  logic [AW-1:0]    BSEL,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             ABUSY,
    output logic             BBUSY,
    output logic [NREG-1:0]  PEND
);

    logic [WIDTH-1:0] regs [1:NREG-1];
    logic [NREG-1:1]  pend_r;

    logic [WIDTH-1:0] a_reg, b_reg;
    logic             a_pend, b_pend;
    logic             a_in, b_in;
    logic             a_byp, b_byp;

    // Set-before-clear ordering lets a new producer reserve the slot its predecessor retires.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
            pend_r <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (WE && DSEL == AW'(i)) begin
                    regs[i] <= RIN;
                end
                if (RSV && RSEL == AW'(i)) begin
                    pend_r[i] <= 1'b1;
                end else if (WE && DSEL == AW'(i)) begin
                    pend_r[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        a_reg  = '0;
        a_pend = 1'b0;
        a_in   = 1'b0;
        b_reg  = '0;
        b_pend = 1'b0;
        b_in   = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (ASEL == AW'(i)) begin
                a_reg  = regs[i];
                a_pend = pend_r[i];
                a_in   = 1'b1;
            end
            if (BSEL == AW'(i)) begin
                b_reg  = regs[i];
                b_pend = pend_r[i];
                b_in   = 1'b1;
            end
        end
    end

    // Forwarding is suppressed while in reset so reads of storage addresses return 0.
    assign a_byp = (BYPASS != 0) && RSTN && WE && a_in && (DSEL == ASEL);
    assign b_byp = (BYPASS != 0) && RSTN && WE && b_in && (DSEL == BSEL);

    assign A     = (ASEL == '0) ? DIN : (a_byp ? RIN : a_reg);
    assign B     = (BSEL == '0) ? DIN : (b_byp ? RIN : b_reg);
    assign ABUSY = a_pend && !a_byp;
    assign BBUSY = b_pend && !b_byp;
    assign PEND  = {pend_r, 1'b0};

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - checks three regfile_param configurations against a behavioural model
module tb_regfile_param;

    logic       CLK = 1'b0;
    logic       RSTN, WE, RSV;
    logic [2:0] DSEL, RSEL, ASEL, BSEL;
    logic [7:0] RIN, DIN;

    logic [7:0] a_act [3];
    logic [7:0] b_act [3];
    logic       ab_act [3];
    logic       bb_act [3];
    logic [7:0] pend_act [3];
    logic [7:0] pend0, pend1;
    logic [5:0] pend2;

    int nerr = 0;
    int ncheck = 0;
    bit chk_en = 0;

    logic [7:0] rm [3][8];
    logic       pm [3][8];

    always #5 CLK = ~CLK;

    // inst 0: NREG=8 bypass; inst 1: NREG=8 no bypass; inst 2: NREG=6 bypass
    regfile_param #(.WIDTH(8), .NREG(8), .AW(3), .BYPASS(1)) u0 (
        .CLK(CLK), .RSTN(RSTN), .WE(WE), .DSEL(DSEL), .RIN(RIN), .RSV(RSV), .RSEL(RSEL),
        .ASEL(ASEL), .BSEL(BSEL), .DIN(DIN), .A(a_act[0]), .B(b_act[0]),
        .ABUSY(ab_act[0]), .BBUSY(bb_act[0]), .PEND(pend0));
    regfile_param #(.WIDTH(8), .NREG(8), .AW(3), .BYPASS(0)) u1 (
        .CLK(CLK), .RSTN(RSTN), .WE(WE), .DSEL(DSEL), .RIN(RIN), .RSV(RSV), .RSEL(RSEL),
        .ASEL(ASEL), .BSEL(BSEL), .DIN(DIN), .A(a_act[1]), .B(b_act[1]),
        .ABUSY(ab_act[1]), .BBUSY(bb_act[1]), .PEND(pend1));
    regfile_param #(.WIDTH(8), .NREG(6), .AW(3), .BYPASS(1)) u2 (
        .CLK(CLK), .RSTN(RSTN), .WE(WE), .DSEL(DSEL), .RIN(RIN), .RSV(RSV), .RSEL(RSEL),
        .ASEL(ASEL), .BSEL(BSEL), .DIN(DIN), .A(a_act[2]), .B(b_act[2]),
        .ABUSY(ab_act[2]), .BBUSY(bb_act[2]), .PEND(pend2));

    assign pend_act[0] = pend0;
    assign pend_act[1] = pend1;
    assign pend_act[2] = {2'b00, pend2};

    function automatic int nreg_of(int k);
        return (k == 2) ? 6 : 8;
    endfunction

    function automatic bit fwd(int k, logic [2:0] sel);
        return (k != 1) && RSTN && WE && (DSEL == sel);
    endfunction

    function automatic logic [7:0] m_read(int k, logic [2:0] sel);
        if (sel == 0) return DIN;
        if (int'(sel) >= nreg_of(k)) return 8'h00;
        if (fwd(k, sel)) return RIN;
        return rm[k][sel];
    endfunction

    function automatic logic m_busy(int k, logic [2:0] sel);
        if (sel == 0 || int'(sel) >= nreg_of(k)) return 1'b0;
        if (fwd(k, sel)) return 1'b0;
        return pm[k][sel];
    endfunction

    function automatic logic [7:0] m_pend(int k);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 1; i < nreg_of(k); i++) v[i] = pm[k][i];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        ncheck++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++) begin
                rm[k][i] = 8'h00;
                pm[k][i] = 1'b0;
            end
    endtask

    // Advance one clock edge, applying the register-file rules to the model with pre-edge inputs.
    task automatic tick();
        @(posedge CLK);
        if (RSTN) begin
            for (int k = 0; k < 3; k++)
                for (int i = 1; i < nreg_of(k); i++) begin
                    if (WE && int'(DSEL) == i) rm[k][i] = RIN;
                    if (RSV && int'(RSEL) == i) pm[k][i] = 1'b1;
                    else if (WE && int'(DSEL) == i) pm[k][i] = 1'b0;
                end
        end
        #1;
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("A[%0d]", k), a_act[k], m_read(k, ASEL));
                chk($sformatf("B[%0d]", k), b_act[k], m_read(k, BSEL));
                chk($sformatf("ABUSY[%0d]", k), {7'b0, ab_act[k]}, {7'b0, m_busy(k, ASEL)});
                chk($sformatf("BBUSY[%0d]", k), {7'b0, bb_act[k]}, {7'b0, m_busy(k, BSEL)});
                chk($sformatf("PEND[%0d]", k), pend_act[k], m_pend(k));
            end
        end
    end

    initial begin
        model_clear();
        RSTN = 1'b0; WE = 0; RSV = 0; DSEL = 0; RSEL = 0; ASEL = 0; BSEL = 0;
        RIN = 8'h00; DIN = 8'h00;
        tick();
        tick();
        RSTN = 1'b1;
        chk_en = 1;
        ASEL = 3'd1; BSEL = 3'd7;
        #1;
        chk("reset_a", a_act[0], 8'h00);
        chk("reset_pend", pend_act[0], 8'h00);

        // reset sweep
        for (int r = 1; r < 8; r++) begin
            WE = 1; DSEL = 3'(r); RIN = 8'hA5;
            tick();
        end
        WE = 0; ASEL = 3'd2; BSEL = 3'd7;
        #1;
        chk("sweep_a", a_act[0], 8'hA5);
        chk("sweep_b", b_act[1], 8'hA5);
        RSTN = 1'b0;
        model_clear();
        #1;
        chk("rst_async_a", a_act[0], 8'h00);
        chk("rst_async_b", b_act[1], 8'h00);
        chk("rst_async_pend", pend_act[0], 8'h00);
        ASEL = 3'd0; DIN = 8'h3C;
        #1;
        chk("rst_din", a_act[0], 8'h3C);
        @(negedge CLK);
        #1 RSTN = 1'b1;

        // write/read and WE gating
        WE = 1; DSEL = 3'd3; RIN = 8'h5A; ASEL = 3'd3; BSEL = 3'd3;
        tick();
        WE = 0;
        #1;
        chk("wr_a_nobyp", a_act[1], 8'h5A);
        chk("wr_b_nobyp", b_act[1], 8'h5A);
        WE = 0; DSEL = 3'd3; RIN = 8'hFF;
        tick();
        chk("we_gate", a_act[0], 8'h5A);
        WE = 1; DSEL = 3'd0; RIN = 8'h77;
        tick();
        WE = 0;
        for (int i = 0; i < 8; i++) begin
            ASEL = 3'(i); BSEL = 3'(7 - i); DIN = 8'(8'h40 + i);
            tick();
        end

        // bypass
        ASEL = 3'd5; WE = 1; DSEL = 3'd5; RIN = 8'h11;
        #1;
        chk("byp_same_cycle", a_act[0], 8'h11);
        chk("nobyp_old", a_act[1], 8'h00);
        tick();
        WE = 0;
        #1;
        chk("nobyp_after", a_act[1], 8'h11);

        // scoreboard
        RSV = 1; RSEL = 3'd4;
        tick();
        RSV = 0; ASEL = 3'd4;
        #1;
        chk("sb_busy", {7'b0, ab_act[0]}, 8'h01);
        chk("sb_pend", pend_act[0], 8'b0001_0000);
        WE = 1; DSEL = 3'd4; RIN = 8'h44;
        #1;
        chk("sb_byp_busy", {7'b0, ab_act[0]}, 8'h00);
        chk("sb_nobyp_busy", {7'b0, ab_act[1]}, 8'h01);
        tick();
        WE = 0;
        #1;
        chk("sb_clear", pend_act[0], 8'h00);

        // simultaneous set/clear
        RSV = 1; RSEL = 3'd2;
        tick();
        WE = 1; DSEL = 3'd2; RIN = 8'h22;
        tick();
        RSV = 0; WE = 0; ASEL = 3'd2;
        #1;
        chk("sim_same_busy", {7'b0, ab_act[0]}, 8'h01);
        chk("sim_same_data", a_act[0], 8'h22);
        chk("sim_same_pend", pend_act[1], 8'b0000_0100);
        RSV = 1; RSEL = 3'd6; WE = 1; DSEL = 3'd2; RIN = 8'h23;
        tick();
        RSV = 0; WE = 0;
        #1;
        chk("sim_diff_pend", pend_act[0], 8'b0100_0000);
        chk("sim_diff_pend6", pend_act[2], 8'h00);

        // non-power-of-2 depth
        WE = 1; DSEL = 3'd6; RIN = 8'h66;
        tick();
        WE = 0; ASEL = 3'd6;
        #1;
        chk("n6_wr_ignored", a_act[2], 8'h00);
        chk("n8_wr6", a_act[0], 8'h66);
        RSV = 1; RSEL = 3'd7;
        tick();
        RSV = 0; ASEL = 3'd7;
        #1;
        chk("n6_rsv_ignored", pend_act[2], 8'h00);
        chk("n6_read7", a_act[2], 8'h00);
        chk("n6_busy7", {7'b0, ab_act[2]}, 8'h00);
        chk("n8_busy7", {7'b0, ab_act[0]}, 8'h01);

        // mixed traffic
        for (int n = 0; n < 60; n++) begin
            WE = 1'($urandom); RSV = 1'($urandom);
            DSEL = 3'($urandom); RSEL = 3'($urandom);
            ASEL = 3'($urandom); BSEL = 3'($urandom);
            RIN = 8'($urandom); DIN = 8'($urandom);
            tick();
        end
        @(negedge CLK);
        #1;
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", nerr, ncheck);
        $finish;
    end

endmodule
